// File: rtl/screen_pkg.sv
// Purpose : shared geometry, command opcodes and FSM state encoding for the screen controller.
// Latency : n/a (definitions only).
// Backpressure: n/a.
package screen_pkg;

  // Screen geometry: 40 x 30 character cells, row-major, cell 0 at top-left.
  localparam int SCREEN_COLS  = 40;
  localparam int SCREEN_ROWS  = 30;
  localparam int SCREEN_CELLS = SCREEN_COLS * SCREEN_ROWS;

  // Cell indices fit in 11 bits (1200 < 2048).
  localparam int CELL_W = 11;

  // Index of the last cell on the screen.
  localparam logic [CELL_W-1:0] LAST_CELL = CELL_W'(SCREEN_CELLS - 1);

  // Last destination cell that a scroll copies; later cells are blanked.
  localparam logic [CELL_W-1:0] SCROLL_LAST = CELL_W'(SCREEN_CELLS - SCREEN_COLS - 1);

  // First cell of row 1, i.e. the source of destination cell 0 during a scroll.
  localparam logic [CELL_W-1:0] ROW1_CELL = CELL_W'(SCREEN_COLS);

  // Engine command opcodes. OP_RSVD behaves exactly like OP_NOP.
  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_CLEAR  = 2'd1,
    OP_SCROLL = 2'd2,
    OP_RSVD   = 2'd3
  } cmd_op_e;

  // Engine FSM states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_SCR_PRIME = 3'd2,
    ST_SCROLL    = 3'd3,
    ST_FILL      = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  // True in every state in which the engine wants the RAM write port.
  function automatic logic is_engine_write(input state_e s);
    return (s == ST_CLEAR) || (s == ST_SCROLL) || (s == ST_FILL);
  endfunction

endpackage

// File: rtl/screen_cell_counter.sv
// Purpose : 11-bit engine cell index counter with synchronous load, count enable and terminal-count compare.
// Latency : load/increment visible the cycle after the request; o_tc is combinational from the count.
// Backpressure: none; the caller withholds i_en to hold the count.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset (count returns to 0)
//   i_load/i_load_val  load a new count (takes priority over i_en)
//   i_en               advance the count by one
//   i_tc_val           terminal value compared against the current count
//   o_cnt / o_tc       current count / count equals i_tc_val
module screen_cell_counter
  import screen_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [CELL_W-1:0] i_load_val,
  input  logic              i_en,
  input  logic [CELL_W-1:0] i_tc_val,
  output logic [CELL_W-1:0] o_cnt,
  output logic              o_tc
);

  logic [CELL_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt + CELL_W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_tc_val);

endmodule

// File: rtl/screen_ctrl.sv
// Purpose : character-screen RAM write arbiter: CPU stores plus a CLEAR / SCROLL fill engine.
// Latency : CPU write same cycle (combinational); CLEAR 1201 and SCROLL 1202 cycles accept-to-done, +1 per stall.
// Backpressure: cmd_ready only in IDLE; a valid CPU store always wins the write port and stalls the engine.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cpu_wr/cpu_addr/cpu_wdata       CPU store; wdata[3:0] is the character code
//   cpu_err                         registered pulse for a store outside the screen window
//   cmd_valid/cmd_op/cmd_fill       engine command request, opcode, fill code
//   cmd_ready/cmd_done              engine idle / pulse after the final engine write
//   mem_we/mem_waddr/mem_wdata      screen RAM write port
//   mem_raddr/mem_rdata             screen RAM read port (1-cycle synchronous read)
module screen_ctrl
  import screen_pkg::*;
#(
  parameter logic [31:0] SCREEN_BASE = 32'h4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_err,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_fill,
  output logic        cmd_ready,
  output logic        cmd_done,
  output logic        mem_we,
  output logic [10:0] mem_waddr,
  output logic [3:0]  mem_wdata,
  output logic [10:0] mem_raddr,
  input  logic [3:0]  mem_rdata
);

  // ---------------------------------------------------------------------------
  // CPU address decode
  // ---------------------------------------------------------------------------
  logic [31:0]       w_offset;
  logic              w_addr_ok;
  logic              w_cpu_we;
  logic [CELL_W-1:0] w_cpu_idx;

  // Lower-bound test first so an address below the base cannot wrap into range.
  assign w_offset  = cpu_addr - SCREEN_BASE;
  assign w_addr_ok = (cpu_addr >= SCREEN_BASE) && (w_offset < 32'(SCREEN_CELLS));
  assign w_cpu_we  = cpu_wr && w_addr_ok;
  assign w_cpu_idx = w_offset[CELL_W-1:0];

  // Only the character code and the in-range offset bits are meaningful.
  logic w_unused;
  assign w_unused = ^{cpu_wdata[31:4], w_offset[31:CELL_W]};

  // ---------------------------------------------------------------------------
  // Engine state
  // ---------------------------------------------------------------------------
  state_e            r_state;
  state_e            w_state_nxt;
  logic [3:0]        r_fill;
  logic              r_cpu_err;

  logic              w_accept;
  logic              w_eng_we;
  logic              w_stall;
  logic              w_adv;
  logic [3:0]        w_eng_dat;

  logic              w_cnt_load;
  logic              w_cnt_en;
  logic [CELL_W-1:0] w_tc_val;
  logic [CELL_W-1:0] w_cnt;
  logic              w_tc;

  assign w_accept = cmd_valid && (r_state == ST_IDLE);
  assign w_eng_we = is_engine_write(r_state);

  // A CPU store takes the port; the engine repeats the same cell next cycle.
  assign w_stall  = w_eng_we && w_cpu_we;
  assign w_adv    = w_eng_we && !w_cpu_we;

  // SCROLL stops copying at the end of row 28; CLEAR and FILL run to the last cell.
  assign w_tc_val = (r_state == ST_SCROLL) ? SCROLL_LAST : LAST_CELL;

  screen_cell_counter u_cell_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val ('0),
    .i_en       (w_cnt_en),
    .i_tc_val   (w_tc_val),
    .o_cnt      (w_cnt),
    .o_tc       (w_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_en    = w_adv;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_cnt_load = 1'b1;
          case (cmd_op_e'(cmd_op))
            OP_CLEAR:  w_state_nxt = ST_CLEAR;
            OP_SCROLL: w_state_nxt = ST_SCR_PRIME;
            default:   w_state_nxt = ST_DONE;
          endcase
        end
      end
      ST_CLEAR: begin
        if (w_adv && w_tc) w_state_nxt = ST_DONE;
      end
      // One cycle with no write while the first source cell is read.
      ST_SCR_PRIME: begin
        w_state_nxt = ST_SCROLL;
      end
      // The counter keeps running into FILL, so FILL starts at the first cell of row 29.
      ST_SCROLL: begin
        if (w_adv && w_tc) w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        if (w_adv && w_tc) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_cnt_load  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_fill    <= 4'h0;
      r_cpu_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cpu_err <= cpu_wr && !w_addr_ok;
      if (w_accept) r_fill <= cmd_fill;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM ports
  // ---------------------------------------------------------------------------
  // During SCROLL the read runs one cell ahead of the write (n+41 vs n+40 source)
  // to cover the RAM latency. On a stall the previous address (n+40) is
  // re-presented so the same source data comes back for the retried write.
  always_comb begin
    mem_raddr = '0;
    if (r_state == ST_SCR_PRIME) begin
      mem_raddr = ROW1_CELL;
    end else if (r_state == ST_SCROLL) begin
      mem_raddr = w_cnt + (w_stall ? CELL_W'(SCREEN_COLS) : CELL_W'(SCREEN_COLS + 1));
    end
  end

  assign w_eng_dat = (r_state == ST_SCROLL) ? mem_rdata : r_fill;

  assign mem_we    = w_cpu_we || w_eng_we;
  assign mem_waddr = w_cpu_we ? w_cpu_idx : w_cnt;
  assign mem_wdata = w_cpu_we ? cpu_wdata[3:0] : w_eng_dat;

  assign cpu_err   = r_cpu_err;
  assign cmd_ready = (r_state == ST_IDLE);
  assign cmd_done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_screen_ctrl.sv
// Purpose : self-checking bench for screen_ctrl with a behavioural RAM and screen model.
// Latency : n/a.
// Backpressure: n/a.
module tb_screen_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_err;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_fill;
  logic        cmd_ready;
  logic        cmd_done;
  logic        mem_we;
  logic [10:0] mem_waddr;
  logic [3:0]  mem_wdata;
  logic [10:0] mem_raddr;
  logic [3:0]  mem_rdata;

  always #5 clk = ~clk;

  screen_ctrl #(.SCREEN_BASE(32'h4000)) dut (
    .clk(clk), .reset(reset),
    .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_err(cpu_err),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_fill(cmd_fill),
    .cmd_ready(cmd_ready), .cmd_done(cmd_done),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  // Screen RAM: synchronous write, 1-cycle synchronous read (old data on collision).
  logic [3:0] ram [0:2047];
  logic [3:0] pre [0:1199];
  logic       preload;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1200; i++) ram[i] <= pre[i];
    end else if (mem_we) begin
      ram[mem_waddr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_raddr];
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: screen contents and latency derived from the command rules
  // ---------------------------------------------------------------------------
  logic [3:0]  mdl [0:1199];
  bit          sch_wr   [0:3071];
  logic [31:0] sch_addr [0:3071];
  logic [31:0] sch_dat  [0:3071];

  function automatic bit addr_ok(input logic [31:0] a);
    return (a >= 32'h4000) && (a <= 32'h4000 + 32'd1199);
  endfunction

  // Cycle k counts from acceptance. A valid CPU store owns the port in its cycle;
  // the engine performs its 1200 writes in order in every other active cycle.
  function automatic int model_run(input logic [1:0] op, input logic [3:0] fill);
    int cnt = 0;
    int k = 0;
    while (cnt < 1200) begin
      k++;
      if (sch_wr[k] && addr_ok(sch_addr[k])) begin
        mdl[sch_addr[k] - 32'h4000] = sch_dat[k][3:0];
      end else if (!(op == 2'd2 && k == 1)) begin
        if (op == 2'd1)     mdl[cnt] = fill;
        else if (cnt < 1160) mdl[cnt] = mdl[cnt + 40];
        else                 mdl[cnt] = fill;
        cnt++;
      end
    end
    return k + 1;
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < 3072; i++) begin
      sch_wr[i] = 1'b0; sch_addr[i] = '0; sch_dat[i] = '0;
    end
  endtask

  task automatic do_preload();
    @(posedge clk); #1 preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;
    for (int i = 0; i < 1200; i++) mdl[i] = pre[i];
  endtask

  // Issue one engine command, replay the CPU schedule, and check latency and RAM.
  task automatic run_engine(input string nm, input logic [1:0] op, input logic [3:0] fill,
                            input int want_lat, input int skip_cell, input bit chk_writes);
    int exp_lat, lat, nwr, errs;
    bit seen;
    exp_lat = model_run(op, fill);
    if (want_lat >= 0) exp_lat = want_lat;
    lat = 0; nwr = 0; seen = 1'b0;
    @(posedge clk); #1;
    cpu_wr = 1'b0; cmd_valid = 1'b1; cmd_op = op; cmd_fill = fill;
    @(negedge clk);
    chk({nm, "_ready"}, cmd_ready, 1'b1);
    for (int k = 1; k <= 3000; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_op = 2'd0; cmd_fill = ~fill;
      cpu_wr = sch_wr[k]; cpu_addr = sch_addr[k]; cpu_wdata = sch_dat[k];
      @(negedge clk);
      if (op == 2'd2 && k == 1) chk({nm, "_prime_raddr"}, mem_raddr, 11'd40);
      if (op == 2'd2 && k == 2 && !sch_wr[k]) chk({nm, "_first_raddr"}, mem_raddr, 11'd41);
      if (mem_we && !cpu_wr) nwr++;
      if (cmd_done) begin
        lat = k; seen = 1'b1;
        break;
      end
    end
    cpu_wr = 1'b0;
    chk({nm, "_done_seen"}, seen, 1'b1);
    chk({nm, "_latency"}, lat, exp_lat);
    if (chk_writes) chk({nm, "_engine_writes"}, nwr, 1200);
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_done_pulse_end"}, cmd_done, 1'b0);
    chk({nm, "_ready_after"}, cmd_ready, 1'b1);
    errs = 0;
    for (int i = 0; i < 1200; i++)
      if (i != skip_cell && ram[i] !== mdl[i]) errs++;
    chk({nm, "_ram_cells_wrong"}, errs, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Table of single-cycle CPU store vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_we;
    logic [10:0] exp_waddr;
    logic [3:0]  exp_wdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [0:7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int errs, k1, k2, k3, nw, kk;
    logic prev_err, exp_we, rwr;
    logic [31:0] raddr, rdat;
    logic [1:0] rop;
    logic [3:0] rfill;

    vecs[0] = '{1'b1, 32'h0000_4005, 32'h0000_0007, 1'b1, 11'd5,    4'h7, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_44B0, 32'h0000_0003, 1'b0, 11'd0,    4'h0, 1'b1};
    vecs[2] = '{1'b1, 32'h0000_4000, 32'hFFFF_FFF3, 1'b1, 11'd0,    4'h3, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_44AF, 32'h0000_002C, 1'b1, 11'd1199, 4'hC, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_3FFF, 32'h0000_0001, 1'b0, 11'd0,    4'h0, 1'b1};
    vecs[5] = '{1'b0, 32'h0000_4005, 32'h0000_0009, 1'b0, 11'd0,    4'h0, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_0000, 32'h0000_0004, 1'b0, 11'd0,    4'h0, 1'b1};
    vecs[7] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0004, 1'b0, 11'd0,    4'h0, 1'b1};

    reset = 1'b1; preload = 1'b0;
    cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_fill = 4'h0;
    clear_sched();

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_done", cmd_done, 1'b0);
    chk("rst_err", cpu_err, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_raddr", mem_raddr, 11'd0);

    // CPU stores during reset still reach RAM; errors are suppressed.
    @(posedge clk); #1 cpu_wr = 1'b1; cpu_addr = 32'h4010; cpu_wdata = 32'h9;
    @(negedge clk);
    chk("rst_cpu_we", mem_we, 1'b1);
    chk("rst_cpu_waddr", mem_waddr, 11'd16);
    @(posedge clk); #1 cpu_addr = 32'h5000;
    @(negedge clk);
    chk("rst_bad_we", mem_we, 1'b0);
    @(posedge clk); #1 cpu_wr = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("rst_err_suppressed", cpu_err, 1'b0);
    chk("rst_ram_written", ram[16], 4'h9);

    // Vector table: store in one cycle, error observed the next.
    for (int v = 0; v < 8; v++) begin
      @(posedge clk); #1;
      cpu_wr = vecs[v].wr; cpu_addr = vecs[v].addr; cpu_wdata = vecs[v].wdata;
      @(negedge clk);
      chk($sformatf("vec%0d_we", v), mem_we, vecs[v].exp_we);
      chk($sformatf("vec%0d_err_same", v), cpu_err, 1'b0);
      if (vecs[v].exp_we) begin
        chk($sformatf("vec%0d_waddr", v), mem_waddr, vecs[v].exp_waddr);
        chk($sformatf("vec%0d_wdata", v), mem_wdata, vecs[v].exp_wdata);
      end
      @(posedge clk); #1 cpu_wr = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_err_next", v), cpu_err, vecs[v].exp_err);
    end

    // Randomised CPU stores with the engine idle.
    prev_err = 1'b0;
    for (int c = 0; c < 300; c++) begin
      rwr = 1'($urandom_range(0, 1));
      case ($urandom % 4)
        0: raddr = 32'h4000 + 32'($urandom_range(0, 1199));
        1: raddr = 32'h4000 + 32'($urandom_range(1200, 1400));
        2: raddr = 32'h4000 - 32'($urandom_range(1, 64));
        default: raddr = $urandom;
      endcase
      rdat = $urandom;
      @(posedge clk); #1;
      cpu_wr = rwr; cpu_addr = raddr; cpu_wdata = rdat;
      @(negedge clk);
      exp_we = rwr && addr_ok(raddr);
      chk("rnd_err", cpu_err, prev_err);
      chk("rnd_we", mem_we, exp_we);
      if (exp_we) begin
        chk("rnd_waddr", mem_waddr, 11'(raddr - 32'h4000));
        chk("rnd_wdata", mem_wdata, rdat[3:0]);
      end
      prev_err = rwr && !addr_ok(raddr);
    end
    @(posedge clk); #1 cpu_wr = 1'b0;
    @(negedge clk);
    chk("rnd_err_last", cpu_err, prev_err);

    // NOP and reserved op: done on the next cycle.
    for (int o = 0; o < 2; o++) begin
      @(posedge clk); #1 cmd_valid = 1'b1; cmd_op = (o == 0) ? 2'd0 : 2'd3;
      @(negedge clk);
      chk($sformatf("nop%0d_ready", o), cmd_ready, 1'b1);
      @(posedge clk); #1 cmd_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("nop%0d_done", o), cmd_done, 1'b1);
      chk($sformatf("nop%0d_busy", o), cmd_ready, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("nop%0d_done_end", o), cmd_done, 1'b0);
    end

    // CLEAR, fill 0xA, no CPU traffic.
    for (int i = 0; i < 1200; i++) pre[i] = 4'h5;
    do_preload();
    clear_sched();
    run_engine("clear", 2'd1, 4'hA, 1201, -1, 1'b1);

    // SCROLL of an index-mod-16 pattern, fill 0.
    for (int i = 0; i < 1200; i++) pre[i] = 4'(i % 16);
    do_preload();
    clear_sched();
    run_engine("scroll", 2'd2, 4'h0, 1202, -1, 1'b1);
    errs = 0;
    for (int n = 0; n < 1200; n++)
      if (ram[n] !== ((n < 1160) ? 4'((n + 40) % 16) : 4'h0)) errs++;
    chk("scroll_closed_form", errs, 0);

    // SCROLL with three CPU stores to 0x4300: three stall cycles.
    for (int i = 0; i < 1200; i++) pre[i] = 4'(i % 16);
    do_preload();
    clear_sched();
    k1 = $urandom_range(3, 360);
    k2 = $urandom_range(400, 760);
    k3 = $urandom_range(800, 1100);
    sch_wr[k1] = 1'b1; sch_addr[k1] = 32'h4300; sch_dat[k1] = 32'($urandom);
    sch_wr[k2] = 1'b1; sch_addr[k2] = 32'h4300; sch_dat[k2] = 32'($urandom);
    sch_wr[k3] = 1'b1; sch_addr[k3] = 32'h4300; sch_dat[k3] = 32'($urandom);
    // Cell 728 copies from the CPU-targeted cell 768, so its value is order dependent.
    run_engine("scroll_stall", 2'd2, 4'h3, 1205, 728, 1'b0);

    // Reset at cycle 600 of a CLEAR aborts it without cmd_done.
    for (int i = 0; i < 1200; i++) pre[i] = 4'h5;
    do_preload();
    @(posedge clk); #1 cmd_valid = 1'b1; cmd_op = 2'd1; cmd_fill = 4'h6;
    for (int k = 1; k < 600; k++) begin
      @(posedge clk); #1 cmd_valid = 1'b0;
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", cmd_ready, 1'b1);
    chk("abort_done", cmd_done, 1'b0);
    chk("abort_we", mem_we, 1'b0);
    errs = 0;
    for (int k = 0; k < 700; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (cmd_done || mem_we) errs++;
    end
    chk("abort_quiet", errs, 0);
    chk("abort_ram_written", ram[100], 4'h6);
    chk("abort_ram_untouched", ram[900], 4'h5);

    for (int i = 0; i < 1200; i++) pre[i] = 4'h5;
    do_preload();
    clear_sched();
    run_engine("clear_after_abort", 2'd1, 4'hC, 1201, -1, 1'b1);

    // Random commands with random CPU traffic, checked against the model.
    for (int r = 0; r < 4; r++) begin
      rop = (($urandom % 2) == 0) ? 2'd1 : 2'd2;
      rfill = 4'($urandom);
      for (int i = 0; i < 1200; i++) pre[i] = 4'($urandom);
      do_preload();
      clear_sched();
      nw = $urandom_range(4, 12);
      for (int j = 0; j < nw; j++) begin
        kk = $urandom_range(3, 1100);
        sch_wr[kk] = 1'b1;
        sch_dat[kk] = $urandom;
        if (($urandom % 4) == 0)
          sch_addr[kk] = 32'h4000 + 32'($urandom_range(1200, 1700));
        else if (rop == 2'd1)
          sch_addr[kk] = 32'h4000 + 32'($urandom_range(0, 1199));
        else
          sch_addr[kk] = 32'h4000 + 32'($urandom_range(0, 39));
      end
      run_engine($sformatf("rand%0d", r), rop, rfill, -1, -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/screen_ctrl.md
SCREEN_CTRL -- requirements
Module: screen_ctrl

Interface
REQ-001 The module SHALL have exactly one clock, clk, and a synchronous, active-high reset named reset.
REQ-002 The ports SHALL be, in order, name / direction / width / meaning:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cpu_wr  in  1  CPU store strobe
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU store data; bits [3:0] are the character code
- cpu_err  out  1  one-cycle pulse: cpu_wr with an out-of-range address
- cmd_valid  in  1  engine command request
- cmd_op  in  2  engine operation (see REQ-008)
- cmd_fill  in  4  fill character code
- cmd_ready  out  1  engine idle; command can be accepted
- cmd_done  out  1  one-cycle pulse after the engine's final write
- mem_we  out  1  write enable to screen RAM
- mem_waddr  out  11  RAM write cell index
- mem_wdata  out  4  RAM write code
- mem_raddr  out  11  engine read cell index
- mem_rdata  in  4  RAM read data (synchronous, 1-cycle latency)

REQ-003 The parameter SHALL be: SCREEN_BASE, default 32'h4000, the CPU address of cell 0.

Function
REQ-004 The screen SHALL be 40 columns x 30 rows = 1200 cells, indexed 0..1199 in row-major order.
REQ-005 A CPU address SHALL be valid iff SCREEN_BASE <= cpu_addr <= SCREEN_BASE+1199; the cell index is cpu_addr-SCREEN_BASE, truncated to 11 bits.
REQ-006 A valid cpu_wr SHALL drive, in the same cycle and combinationally, mem_we=1, mem_waddr=index and mem_wdata=cpu_wdata[3:0]; the CPU always has priority on the write port.
REQ-007 An invalid cpu_wr SHALL produce no RAM write and a cpu_err pulse registered one cycle later.
REQ-008 Ops SHALL be 0=NOP, 1=CLEAR (fill all cells with cmd_fill), 2=SCROLL (move rows 1..29 up one row, then fill row 29 with cmd_fill), 3=reserved (treated as NOP).
REQ-009 A command SHALL be accepted on cmd_valid && cmd_ready; cmd_fill is latched at acceptance. NOP and reserved ops SHALL pulse cmd_done on the next cycle.
REQ-010 The FSM states SHALL be IDLE, CLEAR, SCR_PRIME, SCROLL, FILL and DONE; cmd_ready=1 only in IDLE.
REQ-011 State sequence for CLEAR: IDLE -> CLEAR, writing index n=0..1199, one per granted cycle -> DONE -> IDLE.
REQ-012 State sequence for SCROLL: IDLE -> SCR_PRIME, where mem_raddr=40 -> SCROLL, writing mem[n]=mem_rdata for n=0..1159 with mem_raddr=n+41 presented the same cycle -> FILL, writing n=1160..1199 with the latched fill -> DONE -> IDLE.
REQ-013 DONE SHALL last one cycle, asserting cmd_done=1.
REQ-014 When a valid cpu_wr coincides with an engine write, the engine SHALL stall: the counter does not advance and mem_raddr is held, so mem_rdata is re-presented on the next cycle; no engine write is lost or duplicated.
REQ-015 Unstalled latency SHALL be: CLEAR, acceptance to cmd_done = 1201 cycles; SCROLL = 1202 cycles. Each stall cycle adds exactly one cycle.
REQ-016 A CPU write to a cell during SCROLL/CLEAR SHALL follow last-writer-wins; no coherence beyond that is provided.
REQ-017 mem_raddr SHALL equal 0 outside SCR_PRIME and SCROLL, and mem_we SHALL be 0 when neither CPU nor engine writes.

Reset
REQ-018 On reset, the state SHALL be IDLE, the counter 0, the latched fill 0, cmd_ready=1, and cmd_done=0 and cpu_err=0.
REQ-019 Reset asserted mid-command SHALL abort the command without cmd_done; partially written RAM contents are left as-is.
REQ-020 A cpu_wr in a reset cycle SHALL still write RAM (the path is combinational); cpu_err SHALL be suppressed.

Structure
REQ-021 The package screen_pkg SHALL hold SCREEN_COLS=40, SCREEN_ROWS=30, SCREEN_CELLS=1200, the cmd_op enum and the FSM state enum.
REQ-022 One sub-module, screen_cell_counter (11-bit counter with load, enable and terminal-count compare), SHALL be instantiated for the engine index.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- cpu_wr at addr 0x4005 with data 0x7 -> same-cycle mem_we=1, waddr=5, wdata=7; cpu_err=0.
- cpu_wr at addr 0x44B0 -> mem_we=0; cpu_err pulses on the next cycle.
- CLEAR with fill=0xA, no CPU traffic -> 1200 writes of 0xA to indices 0..1199; cmd_done exactly 1201 cycles after acceptance.
- SCROLL on a RAM model with cell = index mod 16, fill=0 -> final cell n = (n+40) mod 16 for n<1160 and 0 for n>=1160; cmd_done after 1202 cycles.
- SCROLL with cpu_wr to 0x4300 on 3 random cycles -> engine stalls 3 cycles, done at 1205; scroll data intact except any CPU-overwritten cells.
- reset asserted at cycle 600 of CLEAR -> IDLE next cycle, cmd_ready=1, no cmd_done; a new CLEAR then completes normally.
